hazard_ctrl: RTL and testbench

Pipeline hazard/stall controller: the complement of the forwarding unit. It covers every dependency that forwarding cannot resolve:
- load-use;
- ID-stage branch/jr operands not yet available;
- HI/LO accesses while the multi-cycle mult/div unit is busy.

It drives the IF/ID stall enables and the ID/EX bubble, owns the mult/div busy counter, and keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_ctrl.sv | 85 ++++++++
 tb/tb_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl
// Brief   : Pipeline stall controller for load-use, ID-stage branch operands
//           and HI/LO accesses behind the mult/div unit; stall perf counter.
// Revision: 1.0
// ============================================================================
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 32,
  parameter int PERF_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        IFID_rs,
  input  logic [4:0]        IFID_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_branch,
  input  logic              id_md,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic [4:0]        IDEX_WA,
  input  logic              MemtoRegM,
  input  logic [4:0]        EXMEM_WA,
  input  logic              ex_mult,
  input  logic              ex_div,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic              md_busy,
  output logic              md_done,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES);

  logic [5:0] md_cnt;
  logic       rs_e, rt_e, rs_m, rt_m;
  logic       lw_stall, br_stall, md_stall, stall;
  logic       md_start;

  // Register $0 is hardwired, so a zero destination never matches.
  assign rs_e = id_use_rs && (IFID_rs == IDEX_WA)  && (IDEX_WA  != 5'd0);
  assign rt_e = id_use_rt && (IFID_rt == IDEX_WA)  && (IDEX_WA  != 5'd0);
  assign rs_m = id_use_rs && (IFID_rs == EXMEM_WA) && (EXMEM_WA != 5'd0);
  assign rt_m = id_use_rt && (IFID_rt == EXMEM_WA) && (EXMEM_WA != 5'd0);

  assign md_start = ex_mult || ex_div;
  assign md_busy  = (md_cnt != 6'd0);

  assign lw_stall = MemtoRegE && (rs_e || rt_e);
  assign br_stall = id_branch && ((RegWriteE && (rs_e || rt_e)) ||
                                  (MemtoRegM && (rs_m || rt_m)));
  assign md_stall = id_md && (md_busy || md_start);
  assign stall    = lw_stall || br_stall || md_stall;

  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt       <= 6'd0;
      md_done      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      // A new start overrides any op in flight; div takes priority.
      if (ex_div)
        md_cnt <= DIV_LOAD;
      else if (ex_mult)
        md_cnt <= MULT_LOAD;
      else if (md_cnt != 6'd0)
        md_cnt <= md_cnt - 6'd1;

      md_done <= (md_cnt == 6'd1) && !md_start;

      if (stall && (stall_cycles != {PERF_W{1'b1}}))
        stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_ctrl
// Brief   : Scoreboard bench for hazard_ctrl with directed hazard vectors.
// Revision: 1.0
// ============================================================================
module tb_hazard_ctrl;

  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [4:0]    IFID_rs, IFID_rt, IDEX_WA, EXMEM_WA;
  logic          id_use_rs, id_use_rt, id_branch, id_md;
  logic          RegWriteE, MemtoRegE, MemtoRegM, ex_mult, ex_div;
  logic          StallF, StallD, FlushE, md_busy, md_done;
  logic [PW-1:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string nm;
    logic  s;
    logic  b;
    logic  d;
    int    c;
  } exp_t;

  exp_t sbq[$];

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(32), .PERF_W(PW)) dut (
    .clk(clk), .reset(reset),
    .IFID_rs(IFID_rs), .IFID_rt(IFID_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_branch(id_branch), .id_md(id_md),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .IDEX_WA(IDEX_WA),
    .MemtoRegM(MemtoRegM), .EXMEM_WA(EXMEM_WA),
    .ex_mult(ex_mult), .ex_div(ex_div),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .md_busy(md_busy), .md_done(md_done), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
    end
  endtask

  // Monitor: outputs are compared mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk({e.nm, ".StallF"}, 32'(StallF), 32'(e.s));
      chk({e.nm, ".StallD"}, 32'(StallD), 32'(e.s));
      chk({e.nm, ".FlushE"}, 32'(FlushE), 32'(e.s));
      chk({e.nm, ".md_busy"}, 32'(md_busy), 32'(e.b));
      chk({e.nm, ".md_done"}, 32'(md_done), 32'(e.d));
      chk({e.nm, ".stall_cycles"}, 32'(stall_cycles), 32'(e.c));
    end
  end

  task automatic idle();
    IFID_rs = 5'd0; IFID_rt = 5'd0; IDEX_WA = 5'd0; EXMEM_WA = 5'd0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_branch = 1'b0; id_md = 1'b0;
    RegWriteE = 1'b0; MemtoRegE = 1'b0; MemtoRegM = 1'b0;
    ex_mult = 1'b0; ex_div = 1'b0;
  endtask

  // Push the expected view of the current cycle, then advance one clock.
  task automatic issue(input string nm, input logic s, input logic b,
                       input logic d, input int c);
    exp_t e;
    e.nm = nm; e.s = s; e.b = b; e.d = d; e.c = c;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b1;
    #1;
    chk({nm, ".md_busy"}, 32'(md_busy), 32'd0);
    chk({nm, ".md_done"}, 32'(md_done), 32'd0);
    chk({nm, ".stall_cycles"}, 32'(stall_cycles), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    #2 reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst.md_busy", 32'(md_busy), 32'd0);
    chk("rst.md_done", 32'(md_done), 32'd0);
    chk("rst.stall_cycles", 32'(stall_cycles), 32'd0);
    chk("rst.StallF", 32'(StallF), 32'd0);
    reset = 1'b0;

    // Div in flight with mfhi waiting, then async reset at md_cnt = 20
    id_md = 1'b1; ex_div = 1'b1;
    issue("div_start", 1, 0, 0, 0);
    ex_div = 1'b0;
    issue("div_wait1", 1, 1, 0, 1);
    issue("div_wait2", 1, 1, 0, 2);
    id_md = 1'b0;
    for (int k = 3; k <= 12; k++) issue("div_run", 0, 1, 0, 3);
    #2;
    chk("div20.md_busy", 32'(md_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst.md_busy", 32'(md_busy), 32'd0);
    chk("arst.md_done", 32'(md_done), 32'd0);
    chk("arst.stall_cycles", 32'(stall_cycles), 32'd0);
    chk("arst.StallF", 32'(StallF), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Load-use on rs
    MemtoRegE = 1'b1; RegWriteE = 1'b1; IDEX_WA = 5'd8; IFID_rs = 5'd8; id_use_rs = 1'b1;
    issue("lw_rs", 1, 0, 0, 0);
    idle(); MemtoRegM = 1'b1; EXMEM_WA = 5'd8; IFID_rs = 5'd8; id_use_rs = 1'b1;
    issue("lw_rs_mem", 0, 0, 0, 1);
    // Destination $0 never matches
    idle(); MemtoRegE = 1'b1; IDEX_WA = 5'd0; IFID_rs = 5'd0; id_use_rs = 1'b1;
    issue("lw_r0", 0, 0, 0, 1);
    // Unused operand is ignored
    idle(); MemtoRegE = 1'b1; IDEX_WA = 5'd8; IFID_rs = 5'd8; id_use_rs = 1'b0;
    issue("lw_unused", 0, 0, 0, 1);
    // Load-use on rt
    idle(); MemtoRegE = 1'b1; IDEX_WA = 5'd8; IFID_rt = 5'd8; id_use_rt = 1'b1;
    issue("lw_rt", 1, 0, 0, 1);

    // beq on ALU result in EX: one stall
    idle(); id_branch = 1'b1; IFID_rs = 5'd9; id_use_rs = 1'b1; RegWriteE = 1'b1; IDEX_WA = 5'd9;
    issue("br_alu", 1, 0, 0, 2);
    idle(); id_branch = 1'b1; IFID_rs = 5'd9; id_use_rs = 1'b1; EXMEM_WA = 5'd9;
    issue("br_alu_mem", 0, 0, 0, 3);
    // beq on load: two stalls
    idle(); id_branch = 1'b1; IFID_rs = 5'd9; id_use_rs = 1'b1;
    RegWriteE = 1'b1; MemtoRegE = 1'b1; IDEX_WA = 5'd9;
    issue("br_ld_ex", 1, 0, 0, 3);
    idle(); id_branch = 1'b1; IFID_rs = 5'd9; id_use_rs = 1'b1; MemtoRegM = 1'b1; EXMEM_WA = 5'd9;
    issue("br_ld_mem", 1, 0, 0, 4);
    idle(); id_branch = 1'b1; IFID_rs = 5'd9; id_use_rs = 1'b1;
    issue("br_ld_done", 0, 0, 0, 5);
    // Branch against $0 and unused rt never stall
    idle(); id_branch = 1'b1; IFID_rs = 5'd0; id_use_rs = 1'b1;
    RegWriteE = 1'b1; MemtoRegM = 1'b1; IDEX_WA = 5'd0; EXMEM_WA = 5'd0;
    issue("br_r0", 0, 0, 0, 5);
    idle(); id_branch = 1'b1; IFID_rt = 5'd9; id_use_rt = 1'b0; MemtoRegM = 1'b1; EXMEM_WA = 5'd9;
    issue("br_rt_unused", 0, 0, 0, 5);

    // Mult at t with mflo in ID from t: stall t..t+5, done at t+6
    idle(); id_md = 1'b1; ex_mult = 1'b1;
    issue("mul_t0", 1, 0, 0, 5);
    ex_mult = 1'b0;
    for (int k = 1; k <= 5; k++) issue("mul_busy", 1, 1, 0, 5 + k);
    issue("mul_done", 0, 0, 1, 11);
    id_md = 1'b0;
    issue("mul_after", 0, 0, 0, 11);

    // Div at t restarted by mult at t+3: done only at t+9
    idle(); ex_div = 1'b1;
    issue("dr_t0", 0, 0, 0, 11);
    ex_div = 1'b0;
    issue("dr_t1", 0, 1, 0, 11);
    issue("dr_t2", 0, 1, 0, 11);
    ex_mult = 1'b1;
    issue("dr_t3", 0, 1, 0, 11);
    ex_mult = 1'b0;
    for (int k = 4; k <= 8; k++) issue("dr_run", 0, 1, 0, 11);
    issue("dr_done", 0, 0, 1, 11);
    issue("dr_after", 0, 0, 0, 11);

    // Restart on the final busy cycle suppresses that done pulse
    ex_mult = 1'b1;
    issue("rl_t0", 0, 0, 0, 11);
    ex_mult = 1'b0;
    for (int k = 1; k <= 4; k++) issue("rl_run", 0, 1, 0, 11);
    ex_mult = 1'b1;
    issue("rl_restart", 0, 1, 0, 11);
    ex_mult = 1'b0;
    for (int k = 6; k <= 10; k++) issue("rl_nodone", 0, 1, 0, 11);
    issue("rl_done", 0, 0, 1, 11);

    // Simultaneous mult and div: div latency wins
    ex_mult = 1'b1; ex_div = 1'b1;
    issue("both_t0", 0, 0, 0, 11);
    ex_mult = 1'b0; ex_div = 1'b0;
    for (int k = 1; k <= 32; k++) issue("both_run", 0, 1, 0, 11);
    issue("both_done", 0, 0, 1, 11);
    issue("both_after", 0, 0, 0, 11);

    // Saturation of a 4-bit counter over 20 stall cycles
    do_reset("rst2");
    MemtoRegE = 1'b1; IDEX_WA = 5'd8; IFID_rs = 5'd8; id_use_rs = 1'b1;
    for (int i = 0; i < 20; i++) issue("sat", 1, 0, 0, (i < 15) ? i : 15);
    idle();
    issue("sat_hold", 0, 0, 0, 15);
    issue("sat_hold2", 0, 0, 0, 15);

    repeat (3) @(posedge clk);
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
